// File: rtl/tx_module.sv
// tx_module: 8N1 UART transmitter.
// One byte is accepted per request while idle and shifted onto the line LSB first.
// Bit timing comes from a divider of BAUD_DIV clock cycles per bit.
// The line output, busy flag and done pulse are all driven directly by flip-flops.
module tx_module #(
    parameter int BAUD_DIV = 434
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       Tx_En_Sig,
    input  logic [7:0] Tx_Data,
    output logic       Tx_Pin_Out,
    output logic       Tx_Busy,
    output logic       Tx_Done_Sig
);

    // The baud counter must hold values 0..BAUD_DIV-1.
    localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state,     state_nxt;
    logic [CNT_W-1:0] baud_cnt,  baud_cnt_nxt;
    logic [2:0]       bit_idx,   bit_idx_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic             pin_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             baud_wrap;

    // Every wrap of the baud counter ends the bit currently on the line.
    assign baud_wrap = (baud_cnt == BAUD_LAST);

    // Register the state, the counters, the latched byte and all three outputs.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state       <= IDLE;
            baud_cnt    <= '0;
            bit_idx     <= '0;
            // NOTE: the byte register is cleared too, so nothing from an
            // abandoned frame can leak into later behaviour.
            shift_reg   <= '0;
            Tx_Pin_Out  <= 1'b1;
            Tx_Busy     <= 1'b0;
            Tx_Done_Sig <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // the values from before this edge regardless of statement order.
            state       <= state_nxt;
            baud_cnt    <= baud_cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shift_reg   <= shift_nxt;
            Tx_Pin_Out  <= pin_nxt;
            Tx_Busy     <= busy_nxt;
            Tx_Done_Sig <= done_nxt;
        end
    end

    // Compute the next state, the next counter values and the next output levels.
    always_comb begin
        // NOTE: every signal gets a default before the case statement,
        // so no path through it can leave a value unassigned and infer a latch.
        state_nxt    = state;
        baud_cnt_nxt = baud_cnt;
        bit_idx_nxt  = bit_idx;
        shift_nxt    = shift_reg;
        pin_nxt      = Tx_Pin_Out;
        busy_nxt     = Tx_Busy;
        done_nxt     = 1'b0;

        // The baud counter free-runs in every non-idle state and wraps at BAUD_DIV-1.
        if (state != IDLE) begin
            baud_cnt_nxt = baud_wrap ? '0 : (baud_cnt + CNT_ONE);
        end

        case (state)
            IDLE: begin
                baud_cnt_nxt = '0;
                bit_idx_nxt  = '0;
                pin_nxt      = 1'b1;
                busy_nxt     = 1'b0;
                if (Tx_En_Sig) begin
                    // The start bit goes out on the accepting edge itself.
                    shift_nxt = Tx_Data;
                    state_nxt = START;
                    pin_nxt   = 1'b0;
                    busy_nxt  = 1'b1;
                end
            end

            START: begin
                if (baud_wrap) begin
                    state_nxt   = DATA;
                    bit_idx_nxt = 3'd0;
                    pin_nxt     = shift_reg[0];
                end
            end

            DATA: begin
                if (baud_wrap) begin
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                        pin_nxt   = 1'b1;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        pin_nxt     = shift_reg[bit_idx + 3'd1];
                    end
                end
            end

            STOP: begin
                if (baud_wrap) begin
                    // The line stays high; an immediate new request extends this stop bit by one cycle.
                    state_nxt = IDLE;
                    pin_nxt   = 1'b1;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_module.sv
// tb_tx_module: self-checking bench for tx_module.
// It instantiates one DUT with BAUD_DIV=4 and one with the default divider.
// Expected line, busy and done traces are built from the 8N1 frame definition.
// A separate far-end decoder recovers the bytes from the sampled line.
module tb_tx_module;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       en4, en434;
    logic [7:0] data4, data434;
    logic       pin4, busy4, done4;
    logic       pin434, busy434, done434;

    tx_module #(.BAUD_DIV(4)) dut4 (
        .CLK         (clk),
        .RST_n       (rst_n),
        .Tx_En_Sig   (en4),
        .Tx_Data     (data4),
        .Tx_Pin_Out  (pin4),
        .Tx_Busy     (busy4),
        .Tx_Done_Sig (done4)
    );

    tx_module #(.BAUD_DIV(434)) dut434 (
        .CLK         (clk),
        .RST_n       (rst_n),
        .Tx_En_Sig   (en434),
        .Tx_Data     (data434),
        .Tx_Pin_Out  (pin434),
        .Tx_Busy     (busy434),
        .Tx_Done_Sig (done434)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Captured traces (one entry per clock, sampled on the falling edge) and the expected traces.
    logic       cap_pin[$], cap_busy[$], cap_done[$];
    logic       exp_pin[$], exp_busy[$], exp_done[$];
    logic [7:0] got[$];

    // Abort the run if it ever hangs.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic trace_start();
        cap_pin.delete();  cap_busy.delete();  cap_done.delete();
        exp_pin.delete();  exp_busy.delete();  exp_done.delete();
    endtask

    // Record one cycle of DUT outputs; by default the expectation is an idle line.
    task automatic sample(input bit big);
        cap_pin.push_back(big ? pin434 : pin4);
        cap_busy.push_back(big ? busy434 : busy4);
        cap_done.push_back(big ? done434 : done4);
        exp_pin.push_back(1'b1);
        exp_busy.push_back(1'b0);
        exp_done.push_back(1'b0);
    endtask

    // A frame accepted at trace index 'start' occupies 10 bit periods.
    // It is followed by a one-cycle done pulse.
    task automatic model_frame(input int start, input logic [7:0] d, input int b);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        for (int t = 0; t <= 10 * b; t++) begin
            if (start + t < exp_pin.size()) begin
                if (t < 10 * b) begin
                    exp_pin[start + t]  = bits[t / b];
                    exp_busy[start + t] = 1'b1;
                end else begin
                    exp_done[start + t] = 1'b1;
                end
            end
        end
    endtask

    // Index of the first cycle whose captured value differs from the expectation, or -1.
    function automatic int first_bad(input int kind);
        for (int i = 0; i < cap_pin.size(); i++) begin
            case (kind)
                0:       if (cap_pin[i]  !== exp_pin[i])  return i;
                1:       if (cap_busy[i] !== exp_busy[i]) return i;
                default: if (cap_done[i] !== exp_done[i]) return i;
            endcase
        end
        return -1;
    endfunction

    function automatic int count_busy();
        int n = 0;
        for (int i = 0; i < cap_busy.size(); i++) if (cap_busy[i] === 1'b1) n++;
        return n;
    endfunction

    // Far-end receiver: it finds each high-to-low edge and samples every bit mid-period.
    // It accepts the byte only if the stop bit reads high.
    task automatic decode(input int b);
        int         i;
        logic [7:0] v;
        got.delete();
        i = 0;
        while (i < cap_pin.size()) begin
            if (cap_pin[i] === 1'b0 && (i == 0 || cap_pin[i - 1] === 1'b1)) begin
                if (i + b / 2 + 9 * b < cap_pin.size()) begin
                    for (int k = 0; k < 8; k++) v[k] = cap_pin[i + b / 2 + (k + 1) * b];
                    if (cap_pin[i + b / 2 + 9 * b] === 1'b1) got.push_back(v);
                end
                i = i + 10 * b;
            end else begin
                i++;
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        rst_n = 1'b0; en4 = 1'b1; en434 = 1'b1;
        data4 = 8'h5A; data434 = 8'hC3;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pin4, busy4, done4} !== 3'b100)
            $display("FAIL reset_outputs_div4: pin/busy/done=%b required=100", {pin4, busy4, done4});
        else n_pass++;
        n_checks++;
        if ({pin434, busy434, done434} !== 3'b100)
            $display("FAIL reset_outputs_div434: pin/busy/done=%b required=100", {pin434, busy434, done434});
        else n_pass++;
        en4 = 1'b0; en434 = 1'b0;
        rst_n = 1'b1;
        trace_start();
        bad = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            sample(1'b0);
            if ({pin434, busy434, done434} !== 3'b100) bad++;
        end
        n_checks++;
        if (first_bad(0) != -1 || first_bad(1) != -1 || first_bad(2) != -1)
            $display("FAIL idle_hold_div4: cycle %0d not idle, required line=1 busy=0 done=0",
                     first_bad(0));
        else n_pass++;
        n_checks++;
        if (bad != 0)
            $display("FAIL idle_hold_div434: %0d non-idle cycles, required 0", bad);
        else n_pass++;
    endtask

    // Send one byte on the BAUD_DIV=4 unit with a one-cycle request.
    // Tx_Data is scrambled right after acceptance.
    task automatic test_single(input logic [7:0] d, input bit table_check);
        int         idx;
        logic [9:0] want;
        trace_start();
        @(negedge clk);
        en4 = 1'b1; data4 = d;
        for (int t = 0; t < 10 * 4 + 3; t++) begin
            @(negedge clk);
            sample(1'b0);
            if (t == 0) begin en4 = 1'b0; data4 = ~d; end
        end
        model_frame(0, d, 4);
        idx = first_bad(0); n_checks++;
        if (idx != -1) $display("FAIL single_line[%0d] data=%h: line=%b required=%b", idx, d, cap_pin[idx], exp_pin[idx]);
        else n_pass++;
        idx = first_bad(1); n_checks++;
        if (idx != -1) $display("FAIL single_busy[%0d] data=%h: busy=%b required=%b", idx, d, cap_busy[idx], exp_busy[idx]);
        else n_pass++;
        idx = first_bad(2); n_checks++;
        if (idx != -1) $display("FAIL single_done[%0d] data=%h: done=%b required=%b", idx, d, cap_done[idx], exp_done[idx]);
        else n_pass++;
        decode(4); n_checks++;
        if (got.size() != 1 || got[0] !== d)
            $display("FAIL single_decode: frames=%0d first=%h required 1 frame of %h", got.size(),
                     (got.size() > 0) ? got[0] : 8'hxx, d);
        else n_pass++;
        if (table_check) begin
            want = 10'b1101001010;   // samples 0,1,0,1,0,0,1,0,1,1 read from bit 0 upward
            for (int k = 0; k < 10; k++) begin
                n_checks++;
                if (cap_pin[k * 4 + 2] !== want[k])
                    $display("FAIL a5_bit%0d: line=%b required=%b", k, cap_pin[k * 4 + 2], want[k]);
                else n_pass++;
            end
            n_checks++;
            if (count_busy() != 40) $display("FAIL a5_busy_len: busy cycles=%0d required=40", count_busy());
            else n_pass++;
        end
    endtask

    task automatic test_ignore_busy();
        int idx;
        trace_start();
        @(negedge clk);
        en4 = 1'b1; data4 = 8'h00;
        for (int t = 0; t < 10 * 4 + 20; t++) begin
            @(negedge clk);
            sample(1'b0);
            if (t == 0)  en4 = 1'b0;
            if (t == 12) begin en4 = 1'b1; data4 = 8'hFF; end
            if (t == 13) en4 = 1'b0;
        end
        model_frame(0, 8'h00, 4);
        idx = first_bad(0); n_checks++;
        if (idx != -1) $display("FAIL ignore_line[%0d]: line=%b required=%b", idx, cap_pin[idx], exp_pin[idx]);
        else n_pass++;
        idx = first_bad(2); n_checks++;
        if (idx != -1) $display("FAIL ignore_done[%0d]: done=%b required=%b", idx, cap_done[idx], exp_done[idx]);
        else n_pass++;
        decode(4); n_checks++;
        if (got.size() != 1 || got[0] !== 8'h00)
            $display("FAIL ignore_decode: frames=%0d required exactly one 00 frame", got.size());
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int idx, run;
        trace_start();
        @(negedge clk);
        en4 = 1'b1; data4 = 8'h55;
        for (int t = 0; t < 2 * 10 * 4 + 4; t++) begin
            @(negedge clk);
            sample(1'b0);
            if (t == 40) data4 = 8'h0F;
            if (t == 41) en4 = 1'b0;
        end
        model_frame(0, 8'h55, 4);
        model_frame(41, 8'h0F, 4);
        idx = first_bad(0); n_checks++;
        if (idx != -1) $display("FAIL b2b_line[%0d]: line=%b required=%b", idx, cap_pin[idx], exp_pin[idx]);
        else n_pass++;
        idx = first_bad(1); n_checks++;
        if (idx != -1) $display("FAIL b2b_busy[%0d]: busy=%b required=%b", idx, cap_busy[idx], exp_busy[idx]);
        else n_pass++;
        idx = first_bad(2); n_checks++;
        if (idx != -1) $display("FAIL b2b_done[%0d]: done=%b required=%b", idx, cap_done[idx], exp_done[idx]);
        else n_pass++;
        n_checks++;
        if (cap_pin[41] !== 1'b0) $display("FAIL b2b_second_start: line at accept+41=%b required=0", cap_pin[41]);
        else n_pass++;
        run = 0;
        for (int i = 40; i >= 0 && cap_pin[i] === 1'b1; i--) run++;
        n_checks++;
        if (run != 5) $display("FAIL b2b_stop_len: first stop bit=%0d cycles required=5", run);
        else n_pass++;
        decode(4); n_checks++;
        if (got.size() != 2 || got[0] !== 8'h55 || got[1] !== 8'h0F)
            $display("FAIL b2b_decode: frames=%0d required 55 then 0F", got.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int idx;
        trace_start();
        @(negedge clk);
        en4 = 1'b1; data4 = 8'($urandom_range(0, 255));
        for (int t = 0; t < 18; t++) begin
            @(negedge clk);
            sample(1'b0);
            if (t == 0) en4 = 1'b0;
        end
        n_checks++;
        if (cap_busy[17] !== 1'b1) $display("FAIL midrst_prebusy: busy=%b required=1", cap_busy[17]);
        else n_pass++;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pin4, busy4, done4} !== 3'b100)
            $display("FAIL midrst_async: pin/busy/done=%b required=100", {pin4, busy4, done4});
        else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        trace_start();
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            sample(1'b0);
        end
        idx = first_bad(2); n_checks++;
        if (idx != -1 || first_bad(0) != -1)
            $display("FAIL midrst_no_done: cycle %0d after release not idle, required idle line and no done", idx);
        else n_pass++;
        test_single(8'($urandom_range(0, 255)), 1'b0);
    endtask

    task automatic test_default_div();
        int idx;
        trace_start();
        @(negedge clk);
        en434 = 1'b1; data434 = 8'h3C;
        for (int t = 0; t < 10 * 434 + 3; t++) begin
            @(negedge clk);
            sample(1'b1);
            if (t == 0) begin en434 = 1'b0; data434 = 8'hFF; end
        end
        model_frame(0, 8'h3C, 434);
        idx = first_bad(0); n_checks++;
        if (idx != -1) $display("FAIL div434_line[%0d]: line=%b required=%b", idx, cap_pin[idx], exp_pin[idx]);
        else n_pass++;
        idx = first_bad(2); n_checks++;
        if (idx != -1) $display("FAIL div434_done[%0d]: done=%b required=%b", idx, cap_done[idx], exp_done[idx]);
        else n_pass++;
        n_checks++;
        if (count_busy() != 4340) $display("FAIL div434_busy_len: busy cycles=%0d required=4340", count_busy());
        else n_pass++;
        decode(434); n_checks++;
        if (got.size() != 1 || got[0] !== 8'h3C)
            $display("FAIL div434_loopback: frames=%0d required one 3C frame", got.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single(8'hA5, 1'b1);
        for (int r = 0; r < 6; r++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            test_single(8'($urandom_range(0, 255)), 1'b0);
        end
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_default_div();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
